// File: rtl/axi_burst_pkg.sv
// Shared types for the AXI burst writer: FSM state encoding and B-channel response codes.
package axi_burst_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer (master) and a slave.
interface axi_burst_writer_if #(
    parameter int unsigned ASIZE  = 32,
    parameter int unsigned DSIZE  = 64,
    parameter int unsigned IDSIZE = 4,
    parameter int unsigned LSIZE  = 8
) ();

    logic [IDSIZE-1:0]  axi_awid;
    logic [ASIZE-1:0]   axi_awaddr;
    logic [LSIZE-1:0]   axi_awlen;
    logic               axi_awvalid;
    logic               axi_awready;

    logic [DSIZE-1:0]   axi_wdata;
    logic [DSIZE/8-1:0] axi_wstrb;
    logic               axi_wlast;
    logic               axi_wvalid;
    logic               axi_wready;

    logic [IDSIZE-1:0]  axi_bid;
    logic [1:0]         axi_bresp;
    logic               axi_bvalid;
    logic               axi_bready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/axi_burst_writer.sv
// Splits a stream of total_beats words into AXI write bursts, one burst outstanding at a time.
// Optional macro BRESP_CHECK_EN: flag non-OKAY B responses on the sticky resp_err output.
module axi_burst_writer
    import axi_burst_pkg::*;
#(
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned DSIZE     = 64,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned LSIZE     = 8,
    parameter int unsigned ID        = 0,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,

    input  logic               start,
    input  logic [ASIZE-1:0]   base_addr,
    input  logic [31:0]        total_beats,
    input  logic [LSIZE:0]     burst_len,
    output logic               busy,
    output logic               done,
    output logic               resp_err,

    input  logic [DSIZE-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,

    axi_burst_writer_if.master axi
);

    localparam int unsigned BW = LSIZE + 1;

    state_t           state;
    state_t           next_state;
    logic [BW-1:0]    blen;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    beat_cnt;
    logic [BW-1:0]    len_src;
    logic [BW-1:0]    beats_nxt;
    logic [31:0]      remaining;
    logic [31:0]      rem_src;
    logic [ASIZE-1:0] addr_inc;
    logic             w_hs;
    logic             wlast_c;
    logic             b_acc;

    assign axi.axi_awid = IDSIZE'(ID);

    // State register
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) state <= IDLE;
        else            state <= next_state;
    end

    // Next state, W pass-through and the length/remaining sources for the next burst
    always_comb begin
        next_state     = state;
        w_hs           = 1'b0;
        wlast_c        = 1'b0;
        b_acc          = 1'b0;
        s_ready        = 1'b0;
        axi.axi_wvalid = 1'b0;
        axi.axi_wlast  = 1'b0;
        axi.axi_wdata  = s_data;
        axi.axi_wstrb  = '1;
        len_src        = blen;
        rem_src        = remaining - 32'(beats);
        case (state)
            IDLE: begin
                if (start) begin
                    len_src    = (burst_len == '0) ? BW'(1) : burst_len;
                    rem_src    = total_beats;
                    next_state = (total_beats == 32'd0) ? FIN : ADDR;
                end
            end
            ADDR: begin
                if (axi.axi_awvalid && axi.axi_awready) next_state = DATA;
            end
            DATA: begin
                s_ready        = axi.axi_wready;
                axi.axi_wvalid = s_valid;
                wlast_c        = (beat_cnt == beats - BW'(1));
                axi.axi_wlast  = wlast_c;
                w_hs           = s_valid && axi.axi_wready;
                if (w_hs && wlast_c) next_state = RESP;
            end
            RESP: begin
                b_acc = axi.axi_bvalid && (axi.axi_bid == IDSIZE'(ID));
                if (b_acc) next_state = (rem_src != 32'd0) ? ADDR : FIN;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        beats_nxt = (32'(len_src) < rem_src) ? len_src : BW'(rem_src);
        addr_inc  = ASIZE'(32'(beats) * ADDR_STEP);
    end

    // Registered control outputs and burst bookkeeping
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            axi.axi_awvalid <= 1'b0;
            axi.axi_awaddr  <= '0;
            axi.axi_awlen   <= '0;
            axi.axi_bready  <= 1'b0;
            blen            <= '0;
            beats           <= '0;
            beat_cnt        <= '0;
            remaining       <= '0;
        end else begin
            busy            <= (next_state != IDLE);
            done            <= (state == FIN);
            axi.axi_awvalid <= (next_state == ADDR);
            axi.axi_bready  <= (next_state == RESP);
            if (state == IDLE && start) begin
                blen           <= len_src;
                remaining      <= total_beats;
                axi.axi_awaddr <= base_addr;
            end
            // AW fields are loaded only on entry to ADDR so they hold while awready is low
            if (next_state == ADDR && state != ADDR) begin
                beats         <= beats_nxt;
                axi.axi_awlen <= LSIZE'(beats_nxt - BW'(1));
            end
            if (b_acc) begin
                remaining      <= rem_src;
                axi.axi_awaddr <= axi.axi_awaddr + addr_inc;
            end
            if (w_hs) beat_cnt <= wlast_c ? '0 : beat_cnt + BW'(1);
        end
    end

`ifdef BRESP_CHECK_EN
    // Sticky error on any accepted non-OKAY response, cleared by the next start
    always_ff @(posedge axi_aclk) begin
        if (axi_areset)                          resp_err <= 1'b0;
        else if (state == IDLE && start)         resp_err <= 1'b0;
        else if (b_acc && axi.axi_bresp != BRESP_OKAY) resp_err <= 1'b1;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: AXI slave/stream source model plus handshake monitor.
module tb_axi_burst_writer;
    import axi_burst_pkg::*;

    localparam int unsigned TB_ID = 0;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] total_beats;
    logic [8:0]  burst_len;
    logic        busy;
    logic        done;
    logic        resp_err;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;

    axi_burst_writer_if #(.ASIZE(32), .DSIZE(64), .IDSIZE(4), .LSIZE(8)) bus ();

    axi_burst_writer #(
        .ASIZE(32), .DSIZE(64), .IDSIZE(4), .LSIZE(8), .ID(TB_ID), .ADDR_STEP(1)
    ) dut (
        .axi_aclk    (clk),
        .axi_areset  (rst),
        .start       (start),
        .base_addr   (base_addr),
        .total_beats (total_beats),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .resp_err    (resp_err),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .axi         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_awaddr[$];
    logic [7:0]  q_awlen[$];
    logic [63:0] q_wdata[$];
    logic        q_wlast[$];
    int  done_cnt = 0;
    int  viol = 0;
    int  outstanding = 0;
    bit  aw_stall = 0;
    logic [31:0] stall_addr;
    logic [7:0]  stall_len;
    bit  b_hs = 0;
    bit  wl_hs = 0;
    bit  s_hs = 0;
    bit  rnd = 0;
    int  src_idx = 0;
    int  b_count = 0;
    int  err_idx = -1;

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: records handshakes that complete at the next rising edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.axi_awvalid && bus.axi_awready) begin
                q_awaddr.push_back(bus.axi_awaddr);
                q_awlen.push_back(bus.axi_awlen);
                if (outstanding != 0) viol++;
                outstanding++;
            end
            if (bus.axi_bvalid && bus.axi_bready) begin
                b_hs = 1;
                if (outstanding > 0) outstanding--;
            end
            if (bus.axi_wvalid && bus.axi_wready) begin
                q_wdata.push_back(bus.axi_wdata);
                q_wlast.push_back(bus.axi_wlast);
                if (bus.axi_wlast) wl_hs = 1;
            end
            if (s_valid && s_ready) s_hs = 1;
            if (bus.axi_wvalid && !s_valid) viol++;
            if (aw_stall && (!bus.axi_awvalid || bus.axi_awaddr !== stall_addr ||
                             bus.axi_awlen !== stall_len)) viol++;
            aw_stall   = bus.axi_awvalid && !bus.axi_awready;
            stall_addr = bus.axi_awaddr;
            stall_len  = bus.axi_awlen;
            if (done) done_cnt++;
        end else begin
            outstanding = 0;
            aw_stall    = 0;
        end
    end

    // Slave and stream source, updated just after each rising edge
    initial begin
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_bvalid  = 1'b0;
        bus.axi_bid     = 4'(TB_ID);
        bus.axi_bresp   = 2'b00;
        s_valid         = 1'b0;
        s_data          = '0;
        forever begin
            @(posedge clk);
            #1;
            if (b_hs) begin
                b_hs = 0;
                bus.axi_bvalid = 1'b0;
                b_count++;
            end
            if (wl_hs) begin
                wl_hs = 0;
                bus.axi_bvalid = 1'b1;
                bus.axi_bid    = 4'(TB_ID);
                bus.axi_bresp  = (b_count == err_idx) ? 2'b10 : 2'b00;
            end
            if (s_hs) begin
                s_hs = 0;
                src_idx++;
            end
            s_data          = pat(src_idx);
            s_valid         = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axi_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_run();
        q_awaddr.delete();
        q_awlen.delete();
        q_wdata.delete();
        q_wlast.delete();
        done_cnt = 0;
        viol     = 0;
        src_idx  = 0;
        b_count  = 0;
    endtask

    task automatic run_burst(input logic [31:0] base, input int total, input int blen, input bit rand_en);
        int n;
        clear_run();
        rnd = rand_en;
        @(posedge clk); #1;
        base_addr   = base;
        total_beats = 32'(total);
        burst_len   = 9'(blen);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        rnd = 0;
    endtask

    // Reference burst plan: full bursts of eff beats, then the remainder
    task automatic check_bursts(input string tag, input logic [31:0] base, input int total, input int blen);
        int eff;
        int rem;
        int b;
        int k;
        logic [31:0] a;
        eff = (blen == 0) ? 1 : blen;
        rem = total;
        a   = base;
        k   = 0;
        check({tag, "_aw_count"}, 64'(q_awaddr.size()), 64'((total + eff - 1) / eff));
        check({tag, "_w_count"}, 64'(q_wdata.size()), 64'(total));
        while (rem > 0) begin
            b = (rem < eff) ? rem : eff;
            if (k < q_awaddr.size()) begin
                check({tag, "_awaddr"}, q_awaddr[k], a);
                check({tag, "_awlen"}, q_awlen[k], 64'(b - 1));
            end
            a   = a + 32'(b);
            rem = rem - b;
            k++;
        end
        for (int i = 0; i < q_wdata.size(); i++) begin
            check({tag, "_wdata"}, q_wdata[i], pat(i));
            check({tag, "_wlast"}, q_wlast[i], (((i + 1) % eff) == 0) || (i + 1 == total));
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_protocol"}, viol, 0);
    endtask

    initial begin
        logic exp_err;
        int n;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        total_beats = '0;
        burst_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_awvalid", bus.axi_awvalid, 0);
        check("rst_wvalid", bus.axi_wvalid, 0);
        check("rst_wlast", bus.axi_wlast, 0);
        check("rst_bready", bus.axi_bready, 0);
        check("rst_awaddr", bus.axi_awaddr, 0);
        check("rst_awlen", bus.axi_awlen, 0);
        rst = 1'b0;

        // 8 beats in bursts of 4
        run_burst(32'h1000, 8, 4, 0);
        check("t1_aw0", q_awaddr.size() > 0 ? q_awaddr[0] : 32'hx, 32'h1000);
        check("t1_aw1", q_awaddr.size() > 1 ? q_awaddr[1] : 32'hx, 32'h1004);
        check_bursts("t1", 32'h1000, 8, 4);

        // 10 beats: lengths 4,4,2
        run_burst(32'h2000, 10, 4, 0);
        check("t2_len2", q_awlen.size() > 2 ? q_awlen[2] : 8'hx, 8'd1);
        check("t2_aw2", q_awaddr.size() > 2 ? q_awaddr[2] : 32'hx, 32'h2008);
        check_bursts("t2", 32'h2000, 10, 4);

        // Zero-length job: done two cycles after start, no AW
        clear_run();
        @(posedge clk); #1;
        total_beats = 32'd0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t3_busy_fin", busy, 1);
        check("t3_done_early", done, 0);
        @(posedge clk); #1;
        check("t3_done", done, 1);
        check("t3_busy_clr", busy, 0);
        @(posedge clk); #1;
        check("t3_done_once", done, 0);
        check("t3_no_aw", 64'(q_awaddr.size()), 0);

        // Random stalls on stream, AW and W
        run_burst(32'h3000, 12, 5, 1);
        check_bursts("t4", 32'h3000, 12, 5);

        // Error response on the second burst
        err_idx = 1;
        run_burst(32'h0000_0040, 8, 4, 0);
        err_idx = -1;
`ifdef BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("t5_resp_err_after_done", resp_err, exp_err);
        check_bursts("t5", 32'h0000_0040, 8, 4);
        run_burst(32'h0, 0, 4, 0);
        check("t5_resp_err_cleared", resp_err, 0);

        // Reset while the second beat of a 4-beat burst is on the W channel
        clear_run();
        @(posedge clk); #1;
        base_addr   = 32'h5000;
        total_beats = 32'd8;
        burst_len   = 9'd4;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(q_wdata.size() == 1 && bus.axi_wvalid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reached_beat2", 64'(q_wdata.size()), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_awvalid", bus.axi_awvalid, 0);
        check("t6_wvalid", bus.axi_wvalid, 0);
        check("t6_s_ready", s_ready, 0);
        check("t6_bready", bus.axi_bready, 0);
        check("t6_busy", busy, 0);
        check("t6_state", dut.state, IDLE);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt, 0);

        // burst_len of zero behaves as single-beat bursts
        run_burst(32'h10, 3, 0, 0);
        check_bursts("t7", 32'h10, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_writer.md
AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

Interface
REQ-001 Parameter ASIZE, default 32: AXI address width.
REQ-002 Parameter DSIZE, default 64: AXI and stream data width.
REQ-003 Parameter IDSIZE, default 4: AXI ID width.
REQ-004 Parameter LSIZE, default 8: AXI burst length field width.
REQ-005 Parameter ID, default 0: value driven on axi_awid.
REQ-006 Parameter ADDR_STEP, default 1: address increment per data beat.
REQ-007 Clocking SHALL be one clock with a synchronous, active-high reset: axi_aclk in 1, rising edge; axi_areset in 1, synchronous active-high reset.
REQ-008 Control ports: start in 1 (one-cycle pulse); base_addr in ASIZE; total_beats in 32; burst_len in LSIZE+1 (beats per burst, 1..256); busy out 1; done out 1 (one-cycle pulse); resp_err out 1 (sticky).
REQ-009 Stream input ports: s_data in DSIZE; s_valid in 1; s_ready out 1.
REQ-010 AW channel ports: axi_awid out IDSIZE; axi_awaddr out ASIZE; axi_awlen out LSIZE; axi_awvalid out 1; axi_awready in 1.
REQ-011 W channel ports: axi_wdata out DSIZE; axi_wstrb out DSIZE/8; axi_wlast out 1; axi_wvalid out 1; axi_wready in 1.
REQ-012 B channel ports: axi_bid in IDSIZE; axi_bresp in 2; axi_bvalid in 1; axi_bready out 1.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, DATA, RESP, FIN.
REQ-014 IDLE: on start, latch base_addr, total_beats and burst_len, assert busy, clear resp_err; go to FIN if total_beats==0, else ADDR; start is ignored in all other states.
REQ-015 ADDR: beats = min(latched burst_len, remaining); drive axi_awvalid=1, axi_awaddr=current address, axi_awlen=beats-1, axi_awid=ID; hold the AW fields stable until axi_awready; on handshake go to DATA.
REQ-016 DATA: s_ready = axi_wready and axi_wvalid = s_valid (zero-latency pass-through); axi_wdata=s_data; axi_wstrb all ones; axi_wlast=1 on the final beat of the burst; after the wlast handshake go to RESP.
REQ-017 RESP: axi_bready=1; on axi_bvalid with axi_bid==ID, subtract beats from remaining and add beats*ADDR_STEP to the current address (modulo 2^ASIZE, wrap permitted); go to ADDR if remaining>0, else FIN.
REQ-018 FIN: pulse done for exactly one cycle, deassert busy, then return to IDLE.
REQ-019 At most one burst SHALL be outstanding; AW of burst n+1 SHALL NOT issue before the B response of burst n.
REQ-020 s_ready SHALL be 0 outside DATA; axi_wvalid SHALL never be 1 outside DATA.
REQ-021 4 KB boundary splitting is the caller's responsibility; no splitting in this block.
REQ-022 If burst_len is 0, it SHALL be treated as 1.

Reset
REQ-023 Reset SHALL force IDLE; busy, done, resp_err, s_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready = 0; axi_awaddr, axi_awlen = 0.
REQ-024 Reset mid-burst SHALL drop all valids in the following cycle with no completion pulse; the burst is abandoned.

Configuration
REQ-025 With macro BRESP_CHECK_EN defined, an accepted B response with axi_bresp!=0 SHALL set resp_err until the next start; without it, resp_err SHALL be constant 0 and axi_bresp unused.

Structure
REQ-026 State enum and the BRESP OKAY constant SHALL live in shared package axi_burst_pkg.
REQ-027 A single flat module; no sub-module.

Verification
REQ-028 base_addr=0x1000, total_beats=8, burst_len=4, ADDR_STEP=1, always-ready slave -> AW 0x1000 len 3, then AW 0x1004 len 3; wlast on beats 4 and 8; one done pulse.
REQ-029 total_beats=10, burst_len=4 -> awlen 3, 3, 1; addresses base, base+4, base+8.
REQ-030 total_beats=0 -> no AW issued; done two cycles after start.
REQ-031 s_valid and axi_wready randomly toggled at 50% -> data order preserved; no W beat without s_valid; AW fields stable while stalled.
REQ-032 BRESP_CHECK_EN defined, second B response returns 2'b10 -> resp_err=1 after the response, remains 1 after done, and clears on the next start.
REQ-033 Reset asserted during DATA beat 2 of 4 -> next cycle all valids 0, state IDLE, no done pulse.
